// File: rtl/bitpattern_gen.sv
// Serial frame generator: 1-0-1 header, DATA_W payload bits MSB first, optional even
// parity (compiled in when BITPATTERN_PARITY_EN is defined), then one guard 0.
module bitpattern_gen #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              outp,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHdr1  = 3'd1,
    StHdr0  = 3'd2,
    StHdr2  = 3'd3,
    StData  = 3'd4,
    StPar   = 3'd5,
    StGuard = 3'd6
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [CntW-1:0]   cnt_q;
`ifdef BITPATTERN_PARITY_EN
  logic              parity_q;
`endif

  // outp/done are loaded with the value belonging to the state being entered,
  // so they are registered yet line up exactly with the state.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      cnt_q    <= '0;
      outp     <= 1'b0;
      done     <= 1'b0;
`ifdef BITPATTERN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load_valid) begin
            state_q  <= StHdr1;
            outp     <= 1'b1;
            shreg_q  <= load_data;
`ifdef BITPATTERN_PARITY_EN
            parity_q <= ^load_data;
`endif
          end else begin
            outp <= 1'b0;
          end
        end
        StHdr1: begin
          state_q <= StHdr0;
          outp    <= 1'b0;
        end
        StHdr0: begin
          state_q <= StHdr2;
          outp    <= 1'b1;
        end
        StHdr2: begin
          state_q <= StData;
          outp    <= shreg_q[DATA_W-1];
          shreg_q <= shreg_q << 1;
          cnt_q   <= CntLast;
        end
        StData: begin
          if (cnt_q != '0) begin
            outp    <= shreg_q[DATA_W-1];
            shreg_q <= shreg_q << 1;
            cnt_q   <= cnt_q - 1'b1;
          end else begin
`ifdef BITPATTERN_PARITY_EN
            state_q <= StPar;
            outp    <= parity_q;
`else
            state_q <= StGuard;
            outp    <= 1'b0;
            done    <= 1'b1;
`endif
          end
        end
`ifdef BITPATTERN_PARITY_EN
        StPar: begin
          state_q <= StGuard;
          outp    <= 1'b0;
          done    <= 1'b1;
        end
`endif
        StGuard: begin
          state_q <= StIdle;
          outp    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          outp    <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = (state_q == StIdle);
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_bitpattern_gen.sv
// Self-checking bench for bitpattern_gen (DATA_W=8): vector table, corner sequences,
// randomized frames against a frame-level reference model.
module tb_bitpattern_gen;

  localparam int unsigned DW = 8;
`ifdef BITPATTERN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L = 3 + DW + 1 + PAR;

  logic          clock = 1'b0;
  logic          nreset;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          outp;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  bitpattern_gen #(.DATA_W(DW)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .outp       (outp),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: bit i of the line for payload d, i counted from the first header cycle.
  function automatic logic exp_bit(input logic [DW-1:0] d, input int i);
    if (i < 3) return (i != 1);
    if (i < 3 + DW) return d[DW-1-(i-3)];
    if (PAR == 1 && i == 3 + DW) return ^d;
    return 1'b0;
  endfunction

  // Non-overlapping 101 recogniser fed with the observed line; line is 0 before the frame.
  function automatic int count101(input logic [15:0] bits, output int first_idx);
    int n = 0;
    int k = 0;
    first_idx = -1;
    for (int i = 0; i < L; i++) begin
      case (k)
        0: k = bits[i] ? 1 : 0;
        1: k = bits[i] ? 1 : 2;
        default: begin
          if (bits[i]) begin
            n++;
            if (first_idx < 0) first_idx = i;
          end
          k = 0;
        end
      endcase
    end
    return n;
  endfunction

  // Entered at a negedge with the DUT idle; leaves at the negedge of the following IDLE cycle.
  task automatic send_frame(input logic [DW-1:0] d, input bit keep_valid,
                            input logic [DW-1:0] next_d, output logic [15:0] seen);
    seen = '0;
    check("ready_before", load_ready, 1);
    load_valid = 1'b1;
    load_data  = d;
    @(negedge clock);
    if (keep_valid) load_data = next_d;
    else load_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      if (i > 0) @(negedge clock);
      seen[i] = outp;
      check($sformatf("outp[%0d] d=%0h", i, d), outp, exp_bit(d, i));
      check($sformatf("done[%0d] d=%0h", i, d), done, (i == L - 1));
      check($sformatf("busy[%0d] d=%0h", i, d), busy, 1);
    end
    @(negedge clock);
    check("idle_outp", outp, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", load_ready, 1);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          exp_par;
    int            exp_pulses;
  } vec_t;

  vec_t vecs[8];
  logic [15:0] seen;
  int   npulse;
  int   first;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 3};
    vecs[1] = '{8'h07, 1'b1, 1};
    vecs[2] = '{8'h03, 1'b0, 1};
    vecs[3] = '{8'h00, 1'b0, 1};
    vecs[4] = '{8'hFF, 1'b0, 1};
    vecs[5] = '{8'h50, 1'b0, 2};
    vecs[6] = '{8'h55, 1'b0, 3};
    vecs[7] = '{8'h01, 1'b1, 1};

    nreset     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    #2;
    check("rst_outp", outp, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", load_ready, 1);
    @(negedge clock);
    nreset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("post_rst_outp", outp, 0);
      check("post_rst_ready", load_ready, 1);
    end

    // Table of words with hand-derived parity bit and downstream pulse count.
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].data, 1'b0, '0, seen);
      if (PAR == 1) check($sformatf("parity d=%0h", vecs[v].data), seen[11], vecs[v].exp_par);
      npulse = count101(seen, first);
      check($sformatf("pulses d=%0h", vecs[v].data), npulse, vecs[v].exp_pulses);
      check($sformatf("first_pulse d=%0h", vecs[v].data), first, 2);
      if (vecs[v].data == 8'hA5) check("a5_literal", seen[10:0], 11'b10100101101);
    end

    // Back-to-back with load_valid held: second word must not leak into the first frame.
    send_frame(8'h00, 1'b1, 8'hFF, seen);
    check("b2b_first_payload", seen[10:3], 8'h00);
    send_frame(8'hFF, 1'b0, '0, seen);
    check("b2b_second_payload", seen[10:3], 8'hFF);

    // Reset in the middle of the data field.
    load_valid = 1'b1;
    load_data  = 8'hFF;
    @(negedge clock);
    load_valid = 1'b0;
    repeat (4) @(negedge clock);
    check("mid_data_outp", outp, 1);
    check("mid_data_busy", busy, 1);
    nreset = 1'b0;
    #1;
    check("async_rst_outp", outp, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_ready", load_ready, 1);
    @(negedge clock);
    nreset = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      check($sformatf("no_resume_outp[%0d]", c), outp, 0);
      check($sformatf("no_resume_busy[%0d]", c), busy, 0);
    end

    // Randomized words with random idle gaps.
    for (int r = 0; r < 25; r++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clock);
        check("gap_outp", outp, 0);
      end
      send_frame(d, 1'b0, '0, seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
